// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and helpers for the byte-serial memory
//               controller. Contains the FSM state encoding, the access
//               length encodings, and the length-to-byte-count helper.
// Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_e;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  // Number of RAM bytes moved for a MEM access of the given length.
  // The unused encoding 2'b11 is treated as a word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_load.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational sign/zero extension of assembled load data.
//   raw_i    in  32  little-endian assembled bytes
//   len_i    in   2  access length (LEN_B / LEN_H / LEN_W)
//   signed_i in   1  1 = sign-extend, 0 = zero-extend
//   data_o   out 32  extended result
// Revision    : 1.0  initial release
// ============================================================================
module load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  len_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (len_i)
      LEN_B:   data_o = {{24{signed_i & raw_i[7]}},  raw_i[7:0]};
      LEN_H:   data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Byte-serial memory controller between the IF/MEM pipeline
//               stages and an 8-bit unified RAM port. Arbitrates fetches
//               against loads/stores (MEM first), assembles multi-byte reads
//               little-endian and splits stores into byte writes.
//   clk_i, rst_i           clock, asynchronous active-high reset
//   rdy_i                  global ready; low freezes every register
//   if_req_i/if_addr_i     fetch request and address
//   if_flush_i             abort the fetch in progress
//   if_inst_o/if_done_o    fetched instruction and its completion pulse
//   if_stall_req_o         fetch still outstanding
//   mem_req_i/mem_we_i     data access request, 1 = store
//   mem_len_i/mem_signed_i access length and load extension mode
//   mem_addr_i/mem_wdata_i data address and store data
//   mem_rdata_o/mem_done_o extended load data and completion pulse
//   mem_stall_req_o        data access still outstanding
//   ram_din_i              RAM read byte (one edge after its address)
//   ram_dout_o/ram_addr_o  RAM write byte and byte address
//   ram_wr_o               RAM write enable
// Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int IF_BYTES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rdy_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  output logic              if_stall_req_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic              mem_signed_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              mem_stall_req_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o
);

  state_e            state_q,     state_d;
  logic [2:0]        cnt_q,       cnt_d;
  logic [2:0]        nbytes_q,    nbytes_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [7:0]        ram_dout_q,  ram_dout_d;
  logic              ram_wr_q,    ram_wr_d;
  logic [1:0]        len_q,       len_d;
  logic              signed_q,    signed_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [31:0]       buf_q,       buf_d;
  logic [31:0]       if_inst_q,   if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q,   if_done_d;
  logic              mem_done_q,  mem_done_d;

  logic [1:0]        cap_idx;
  logic [1:0]        wr_idx;
  logic [31:0]       raw_data;
  logic [31:0]       ext_data;

  // The byte arriving on ram_din_i this cycle belongs to index cnt-1 (the
  // address was driven two edges earlier). Merging it here lets the final
  // byte reach the outputs on the same edge that raises done.
  always_comb begin
    cap_idx  = 2'(cnt_q - 3'd1);
    raw_data = buf_q;
    raw_data[{cap_idx, 3'b000} +: 8] = ram_din_i;
  end

  assign wr_idx = 2'(cnt_q + 3'd1);

  load_ext u_load_ext (
    .raw_i    (raw_data),
    .len_i    (len_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    len_d       = len_q;
    signed_d    = signed_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Blocking accepts while a done pulse is out keeps the retiring
        // request (still asserted this cycle) from being taken twice.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req_i) begin
            ram_addr_d = mem_addr_i;
            len_d      = mem_len_i;
            signed_d   = mem_signed_i;
            wdata_d    = mem_wdata_i;
            nbytes_d   = len_to_bytes(mem_len_i);
            cnt_d      = 3'd0;
            buf_d      = 32'd0;
            if (mem_we_i) begin
              state_d    = ST_MEM_WR;
              ram_dout_d = mem_wdata_i[7:0];
              ram_wr_d   = 1'b1;
            end else begin
              state_d = ST_MEM_RD;
            end
          end else if (if_req_i && !if_flush_i) begin
            ram_addr_d = if_addr_i;
            len_d      = LEN_W;
            signed_d   = 1'b0;
            nbytes_d   = 3'(IF_BYTES);
            cnt_d      = 3'd0;
            buf_d      = 32'd0;
            state_d    = ST_IF_RD;
          end
        end
      end

      ST_IF_RD, ST_MEM_RD: begin
        if (state_q == ST_IF_RD && if_flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) buf_d = raw_data;
          // Address walks forward until the last byte, then parks there.
          if (cnt_q + 3'd1 < nbytes_q) ram_addr_d = ram_addr_q + ADDR_W'(1);
          if (cnt_q == nbytes_q) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            if (state_q == ST_IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = raw_data;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = ext_data;
            end
          end
        end
      end

      ST_MEM_WR: begin
        if (cnt_q + 3'd1 < nbytes_q) begin
          cnt_d      = cnt_q + 3'd1;
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
        end else begin
          state_d    = ST_IDLE;
          cnt_d      = 3'd0;
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      ram_addr_q  <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      len_q       <= 2'd0;
      signed_q    <= 1'b0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else if (rdy_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      len_q       <= len_d;
      signed_q    <= signed_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_inst_o       = if_inst_q;
  assign if_done_o       = if_done_q;
  assign mem_rdata_o     = mem_rdata_q;
  assign mem_done_o      = mem_done_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_dout_o      = ram_dout_q;
  // A frozen write must not repeat the same byte on every stalled edge.
  assign ram_wr_o        = ram_wr_q & rdy_i;
  assign if_stall_req_o  = if_req_i & ~if_done_q;
  assign mem_stall_req_o = mem_req_i & ~mem_done_q;

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the IF and MEM stages and the 8-bit unified RAM port.
- Arbitrates instruction fetches and data loads/stores, and assembles or splits multi-byte accesses.
- Raises if_stall_req_o and mem_stall_req_o, which the stall bus turns into pipeline stall and bubble enables.
- Any access takes several cycles, so this block is the main source of stall requests in the pipeline.

Parameters:
ADDR_W, 32, address width of the requests and of ram_addr_o.
IF_BYTES, 4, bytes per instruction fetch.

Ports:
clk_i  in  1  clock; every register updates on the rising edge.
rst_i  in  1  asynchronous, active-high reset.
rdy_i  in  1  global ready; while low the block freezes.
if_req_i  in  1  IF fetch request, held until if_done_o.
if_addr_i  in  ADDR_W  fetch address.
if_flush_i  in  1  abort the fetch in progress (branch redirect).
if_inst_o  out  32  assembled instruction, little-endian.
if_done_o  out  1  one-cycle pulse when if_inst_o is valid.
if_stall_req_o  out  1  IF needs a stall.
mem_req_i  in  1  MEM access request, held until mem_done_o.
mem_we_i  in  1  1 = store, 0 = load.
mem_len_i  in  2  00 byte, 01 half, 10 word.
mem_signed_i  in  1  sign-extend loads.
mem_addr_i  in  ADDR_W  data address.
mem_wdata_i  in  32  store data; the low bytes are used.
mem_rdata_o  out  32  load data after extension.
mem_done_o  out  1  one-cycle completion pulse.
mem_stall_req_o  out  1  MEM needs a stall.
ram_din_i  in  8  RAM read data, valid one edge after the address edge.
ram_dout_o  out  8  RAM write byte.
ram_addr_o  out  ADDR_W  RAM byte address.
ram_wr_o  out  1  RAM write enable.

Behaviour:
- Reset values: state IDLE; every output and internal register is 0.
- Reset is asynchronous, so ram_wr_o drops immediately, including in the middle of a write.
- States: IDLE, IF_RD, MEM_RD, MEM_WR. A byte counter cnt runs from 0 to N, with N = 1, 2 or 4.
- IDLE arbitration:
  - MEM has priority over IF.
  - No request is accepted in a cycle where if_done_o or mem_done_o is high, which prevents re-accepting a retiring request.
  - An accepted IF request is ignored if if_flush_i is high in the same cycle.
- Accept edge: register the base address, the length and the store data; set ram_addr_o = base; cnt <= 0.
- Reads (IF_RD with N = 4, MEM_RD with N = len):
  - Byte k's address is driven after edge k.
  - Byte k is captured from ram_din_i at edge k+2.
  - The done pulse is registered at edge N+1 after the accept edge, so a word takes 5 edges and a byte takes 2.
  - ram_addr_o increments while k < N and then holds.
- Writes (MEM_WR):
  - After edge k, drive ram_addr_o = base+k, ram_dout_o = wdata[8k+7:8k] and ram_wr_o = 1.
  - At edge N: ram_wr_o <= 0, mem_done_o <= 1.
- Completion: the state returns to IDLE on the same edge that sets done. The next accept can happen 2 edges after the last data edge.
- Address alignment: every address is handled byte by byte, so any alignment is legal. Address arithmetic wraps modulo 2^ADDR_W.
- Load extension:
  - Byte: bits [31:8] are filled with bit 7 if mem_signed_i, else 0.
  - Half: the same rule using bit 15.
  - Word: passed through unchanged.
- Output hold: mem_rdata_o and if_inst_o hold their values until the next completion of the same kind.
- Stall requests (combinational): if_stall_req_o = if_req_i & ~if_done_o; mem_stall_req_o = mem_req_i & ~mem_done_o.
- if_flush_i during IF_RD: go to IDLE at the next edge, with no if_done_o and if_inst_o unchanged. A flush has no effect in the other states.
- rdy_i low:
  - No register changes, and cnt and state hold.
  - ram_wr_o is forced to 0 combinationally.
  - The interrupted byte is re-driven when rdy_i returns, so no byte is lost or duplicated.
  - Read capture is stalled the same way; the RAM is required to also hold while rdy_i is low.
- Simultaneous flush and rst_i: reset wins.

Decomposition:
- Package mem_ctrl_pkg: state enum; LEN_B/LEN_H/LEN_W encodings; function len_to_bytes.
- One sub-module, load_ext: purely combinational sign/zero extension of (raw 32, len, signed).

Test Plan:
- IF fetch at 0x00001000, RAM holds 13 05 00 00:
  - if_done_o pulses 5 edges after accept; if_inst_o = 0x00000513.
  - if_stall_req_o is high until the done cycle.
- if_req and mem_req rise together, signed lb at 0x20 holding 0x80:
  - MEM wins; mem_rdata_o = 0xFFFFFF80 after 2 edges.
  - IF is accepted the edge after mem_done_o.
  - Repeating as lbu gives 0x00000080.
- sw 0xDEADBEEF at 0x100:
  - RAM sees writes EF, BE, AD, DE to 0x100..0x103 on 4 consecutive edges.
  - mem_done_o pulses with ram_wr_o = 0.
- Unaligned lh at 0x103, bytes 0xFE 0x7F: mem_rdata_o = 0x00007FFE.
- if_flush_i at cnt = 2 of a fetch:
  - IDLE next edge; no if_done_o; if_inst_o unchanged.
  - A new fetch is accepted the edge after.
- Interruptions mid-write:
  - rdy_i low for 3 cycles mid-write: ram_wr_o is low during the stall; all 4 bytes are written exactly once.
  - rst_i asserted mid-write: ram_wr_o goes to 0 immediately and all outputs take their reset values.
